// File: rtl/irda_pkg.sv
// Shared definitions for the IrDA transmit scheduler: FSM state encoding,
// byte width and width helpers for pointer/counter registers.
package irda_pkg;

    localparam int IRDA_BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_SEND = 2'b10,
        ST_TURN = 2'b11
    } irda_state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Register width able to hold 0..value-1, never narrower than one bit.
    function automatic int idx_w(input int value);
        return (value <= 1) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/irda_rr_arbiter.sv
// Combinational round-robin winner select. Search starts one past the
// last-granted pointer and wraps; the first asserted request wins.
// The pointer itself is owned and updated by the scheduler.
module irda_rr_arbiter
    import irda_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [PTR_W-1:0]   winner_o,
    output logic               valid_o
);

    localparam int            CW1 = PTR_W + 1;
    localparam logic [CW1-1:0] NR = CW1'(NUM_REQ);

    logic [CW1-1:0] cand;

    // Scan from the farthest candidate back to ptr+1 so the nearest set request wins.
    always_comb begin
        valid_o  = 1'b0;
        winner_o = '0;
        cand     = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = {1'b0, ptr_i} + CW1'(i);
            if (cand >= NR) begin
                cand = cand - NR;
            end
            if (req_i[cand[PTR_W-1:0]]) begin
                valid_o  = 1'b1;
                winner_o = cand[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/irda_tx_scheduler.sv
// Shares one IrDA transmitter among NUM_REQ byte requesters.
// Round-robin grant, one frame per grant, no grant while the receiver is
// mid-frame, and the receiver is muted from LOAD through a TURN_CYCLES guard
// after tx_done so it never decodes its own echo.
// Optional SEND watchdog: define IRDA_SCHED_TIMEOUT_EN to enable it; without
// the macro err is tied low and SEND waits for tx_done indefinitely.
// Handshake: req is a level held by the requester until its gnt pulse; gnt and
// tx_load are one-cycle pulses in the same cycle with tx_data valid alongside;
// tx_done is a one-cycle pulse only honoured in SEND.
module irda_tx_scheduler
    import irda_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TURN_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ena,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*IRDA_BYTE_W-1:0] data_in,
    output logic [NUM_REQ-1:0]             gnt,
    input  logic                           rx_busy,
    input  logic                           tx_done,
    output logic                           tx_load,
    output logic [IRDA_BYTE_W-1:0]         tx_data,
    output logic                           rx_mute,
    output logic                           err,
    output irda_state_e                    dbg_state_o,
    output logic [idx_w(NUM_REQ)-1:0]      dbg_ptr_o,
    output logic [idx_w(TURN_CYCLES)-1:0]  dbg_cnt_o
);

    localparam int PW = idx_w(NUM_REQ);
    localparam int CW = idx_w(TURN_CYCLES);
    localparam logic [CW-1:0] TURN_LOAD = CW'(TURN_CYCLES - 1);
    localparam logic [PW-1:0] PTR_RST   = PW'(NUM_REQ - 1);

    if (NUM_REQ < 1 || NUM_REQ > 8 || TURN_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("irda_tx_scheduler: parameter out of range");
    end

    irda_state_e            state_q;
    logic [PW-1:0]          ptr_q;
    logic [CW-1:0]          cnt_q;
    logic [IRDA_BYTE_W-1:0] tx_data_q;
    logic [NUM_REQ-1:0]     gnt_q;
    logic                   tx_load_q;
    logic                   rx_mute_q;

    logic [PW-1:0]          arb_winner;
    logic                   arb_valid;
    logic [IRDA_BYTE_W-1:0] sel_data_d;
    logic [NUM_REQ-1:0]     gnt_d;

`ifdef IRDA_SCHED_TIMEOUT_EN
    localparam int WW = idx_w(TIMEOUT_CYCLES);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
    logic [WW-1:0] wd_q;
    logic          err_q;
`endif

    irda_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PW)
    ) u_arb (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .winner_o (arb_winner),
        .valid_o  (arb_valid)
    );

    // Pick the winning requester's byte out of the packed data bus.
    always_comb begin
        sel_data_d = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_winner == PW'(k)) begin
                sel_data_d = data_in[k*IRDA_BYTE_W +: IRDA_BYTE_W];
            end
        end
    end

    // One-hot grant for the requester latched in the pointer.
    always_comb begin
        gnt_d = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (ptr_q == PW'(k)) begin
                gnt_d[k] = 1'b1;
            end
        end
    end

    // Scheduler FSM; pulses default low every cycle so ena=0 forces them off.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= PTR_RST;
            cnt_q     <= '0;
            tx_data_q <= '0;
            gnt_q     <= '0;
            tx_load_q <= 1'b0;
            rx_mute_q <= 1'b0;
`ifdef IRDA_SCHED_TIMEOUT_EN
            wd_q      <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            gnt_q     <= '0;
            tx_load_q <= 1'b0;
`ifdef IRDA_SCHED_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            if (ena) begin
                case (state_q)
                    ST_IDLE: begin
                        // rx_busy blocks the grant even with requests pending
                        if (!rx_busy && arb_valid) begin
                            tx_data_q <= sel_data_d;
                            ptr_q     <= arb_winner;
                            rx_mute_q <= 1'b1;
                            state_q   <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        tx_load_q <= 1'b1;
                        gnt_q     <= gnt_d;
                        state_q   <= ST_SEND;
`ifdef IRDA_SCHED_TIMEOUT_EN
                        wd_q      <= '0;
`endif
                    end
                    ST_SEND: begin
                        if (tx_done) begin
                            cnt_q   <= TURN_LOAD;
                            state_q <= ST_TURN;
                        end
`ifdef IRDA_SCHED_TIMEOUT_EN
                        else if (wd_q == WD_LAST) begin
                            err_q   <= 1'b1;
                            cnt_q   <= TURN_LOAD;
                            state_q <= ST_TURN;
                        end else begin
                            wd_q <= wd_q + 1'b1;
                        end
`endif
                    end
                    ST_TURN: begin
                        if (cnt_q == '0) begin
                            rx_mute_q <= 1'b0;
                            state_q   <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign gnt         = gnt_q;
    assign tx_load     = tx_load_q;
    assign tx_data     = tx_data_q;
    assign rx_mute     = rx_mute_q;
    assign dbg_state_o = state_q;
    assign dbg_ptr_o   = ptr_q;
    assign dbg_cnt_o   = cnt_q;

`ifdef IRDA_SCHED_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_irda_tx_scheduler.sv
// Bench for irda_tx_scheduler: directed scenarios plus a randomized
// round-robin run checked against a transaction-level model.
module tb_irda_tx_scheduler;

    localparam int NR   = 4;
    localparam int TURN = 16;
    localparam int TMO  = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena = 1'b0;
    logic        rx_busy = 1'b0;
    logic        tx_done = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] data_in = '0;
    logic [3:0]  gnt;
    logic        tx_load;
    logic [7:0]  tx_data;
    logic        rx_mute;
    logic        err;
    logic [1:0]  dbg_state;
    logic [1:0]  dbg_ptr;
    logic [3:0]  dbg_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int m_ptr = NR - 1;

    logic [7:0] exp_q[$];
    int         exp_w_q[$];

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_LOAD = 2'b01;
    localparam logic [1:0] S_SEND = 2'b10;
    localparam logic [1:0] S_TURN = 2'b11;

    irda_tx_scheduler #(
        .NUM_REQ        (NR),
        .TURN_CYCLES    (TURN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .req         (req),
        .data_in     (data_in),
        .gnt         (gnt),
        .rx_busy     (rx_busy),
        .tx_done     (tx_done),
        .tx_load     (tx_load),
        .tx_data     (tx_data),
        .rx_mute     (rx_mute),
        .err         (err),
        .dbg_state_o (dbg_state),
        .dbg_ptr_o   (dbg_ptr),
        .dbg_cnt_o   (dbg_cnt)
    );

    // clock
    always #5 clk = ~clk;

    // hard stop in case something wedges
    initial begin
        #500000;
        $display("FAIL global_timeout: got no summary expected finish");
        $fatal(1, "simulation stopped by watchdog");
    end

    // round-robin rule: first set request after ptr, wrapping
    function automatic int rr_pick(input int ptr, input logic [3:0] mask);
        for (int i = 1; i <= NR; i++) begin
            if (mask[(ptr + i) % NR]) return (ptr + i) % NR;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int idx);
        return 4'(1 << idx);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b0; req = '0; ena = 1'b1; rx_busy = 1'b0; tx_done = 1'b0;
        tick();
        rst = 1'b1;
        m_ptr = NR - 1;
    endtask

    task automatic send_frame(input int f);
        repeat (f - 1) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic wait_load(input int budget, output int waited);
        waited = 0;
        while (tx_load !== 1'b1 && waited < budget) begin
            tick();
            waited++;
        end
        total++;
        if (tx_load !== 1'b1) begin bad++; $display("FAIL load_wait: got tx_load=%b after %0d cycles expected 1", tx_load, waited); end
    endtask

    task automatic test_reset();
        rst = 1'b0; ena = 1'b1; req = 4'hF; data_in = $urandom; rx_busy = 1'b0; tx_done = 1'b0;
        tick(); tick();
        total++; if (dbg_state !== S_IDLE) begin bad++; $display("FAIL reset_state: got %b expected %b", dbg_state, S_IDLE); end
        total++; if (dbg_ptr !== 2'd3) begin bad++; $display("FAIL reset_ptr: got %0d expected 3", dbg_ptr); end
        total++; if (gnt !== 4'b0) begin bad++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        total++; if (tx_load !== 1'b0) begin bad++; $display("FAIL reset_tx_load: got %b expected 0", tx_load); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        total++; if (rx_mute !== 1'b0) begin bad++; $display("FAIL reset_rx_mute: got %b expected 0", rx_mute); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b expected 0", err); end
        rst = 1'b1; req = '0; m_ptr = NR - 1;
        tick();
    endtask

    task automatic test_single();
        int e;
        data_in = $urandom;
        data_in[15:8] = 8'hA5;
        req = 4'b0010;
        tick();
        total++; if (tx_load !== 1'b0 || rx_mute !== 1'b1) begin bad++; $display("FAIL single_load_cycle: got tx_load=%b rx_mute=%b expected 0 1", tx_load, rx_mute); end
        tick();
        total++; if (tx_load !== 1'b1 || gnt !== 4'b0010) begin bad++; $display("FAIL single_grant: got tx_load=%b gnt=%b expected 1 0010", tx_load, gnt); end
        total++; if (tx_data !== 8'hA5) begin bad++; $display("FAIL single_data: got %h expected a5", tx_data); end
        m_ptr = 1;
        req = '0;
        data_in[15:8] = 8'h5A;
        e = 0;
        for (int i = 1; i <= 19; i++) begin
            tick();
            if (rx_mute !== 1'b1 || tx_load !== 1'b0 || gnt !== 4'b0) e++;
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        if (rx_mute !== 1'b1) e++;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (rx_mute !== 1'b1) e++;
        end
        total++; if (e != 0) begin bad++; $display("FAIL single_mute_window: got %0d bad cycles expected 0", e); end
        tick();
        total++; if (rx_mute !== 1'b0 || dbg_state !== S_IDLE) begin bad++; $display("FAIL single_mute_release: got mute=%b state=%b expected 0 00", rx_mute, dbg_state); end
        total++; if (tx_data !== 8'hA5) begin bad++; $display("FAIL single_data_hold: got %h expected a5", tx_data); end
        // stray tx_done in IDLE must be ignored
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        total++; if (rx_mute !== 1'b0 || dbg_state !== S_IDLE) begin bad++; $display("FAIL stray_done: got mute=%b state=%b expected 0 00", rx_mute, dbg_state); end
    endtask

    task automatic test_round_robin();
        int order[5];
        int waited, f, prev_f, prev_cyc;
        order = '{0, 1, 2, 3, 0};
        prev_f = 0; prev_cyc = 0;
        do_reset();
        data_in = $urandom;
        req = 4'hF;
        for (int g = 0; g < 5; g++) begin
            wait_load((g == 0) ? 4 : 60, waited);
            total++; if (gnt !== onehot(order[g])) begin bad++; $display("FAIL rr_order_%0d: got %b expected %b", g, gnt, onehot(order[g])); end
            total++; if (tx_data !== data_in[order[g]*8 +: 8]) begin bad++; $display("FAIL rr_data_%0d: got %h expected %h", g, tx_data, data_in[order[g]*8 +: 8]); end
            if (g == 0) begin
                total++; if (waited != 2) begin bad++; $display("FAIL rr_first_latency: got %0d expected 2", waited); end
            end else begin
                total++; if (cyc - prev_cyc != prev_f + 18) begin bad++; $display("FAIL rr_spacing_%0d: got %0d expected %0d", g, cyc - prev_cyc, prev_f + 18); end
            end
            m_ptr = order[g];
            prev_cyc = cyc;
            f = $urandom_range(1, 12);
            prev_f = f;
            if (g == 4) req = '0;
            send_frame(f);
        end
        repeat (16) tick();
        total++; if (rx_mute !== 1'b0 || dbg_state !== S_IDLE) begin bad++; $display("FAIL rr_end_idle: got mute=%b state=%b expected 0 00", rx_mute, dbg_state); end
    endtask

    task automatic test_rx_priority();
        int e;
        e = 0;
        rx_busy = 1'b1;
        req = 4'b0001;
        repeat (6) begin
            tick();
            if (gnt !== 4'b0 || tx_load !== 1'b0 || dbg_state !== S_IDLE || rx_mute !== 1'b0) e++;
        end
        total++; if (e != 0) begin bad++; $display("FAIL rxbusy_block: got %0d granting cycles expected 0", e); end
        rx_busy = 1'b0;
        tick();
        total++; if (gnt !== 4'b0) begin bad++; $display("FAIL rxbusy_early: got %b expected 0000", gnt); end
        tick();
        total++; if (gnt !== 4'b0001 || tx_load !== 1'b1) begin bad++; $display("FAIL rxbusy_release: got gnt=%b load=%b expected 0001 1", gnt, tx_load); end
        m_ptr = 0;
        req = '0;
        send_frame(5);
        repeat (16) tick();
    endtask

    task automatic test_ena_freeze();
        int e;
        logic [7:0] b;
        b = 8'($urandom);
        data_in[23:16] = b;
        req = 4'b0100;
        tick();
        total++; if (dbg_state !== S_LOAD) begin bad++; $display("FAIL ena_enter_load: got %b expected %b", dbg_state, S_LOAD); end
        ena = 1'b0;
        e = 0;
        repeat (3) begin
            tick();
            if (tx_load !== 1'b0 || gnt !== 4'b0 || dbg_state !== S_LOAD) e++;
        end
        total++; if (e != 0) begin bad++; $display("FAIL ena_load_hold: got %0d bad cycles expected 0", e); end
        ena = 1'b1;
        tick();
        total++; if (tx_load !== 1'b1 || gnt !== 4'b0100 || tx_data !== b) begin bad++; $display("FAIL ena_load_pulse: got load=%b gnt=%b data=%h expected 1 0100 %h", tx_load, gnt, tx_data, b); end
        m_ptr = 2;
        req = '0;
        send_frame(4);
        repeat (10) tick();
        total++; if (dbg_cnt !== 4'd5 || dbg_state !== S_TURN) begin bad++; $display("FAIL ena_turn_count: got cnt=%0d state=%b expected 5 11", dbg_cnt, dbg_state); end
        ena = 1'b0;
        e = 0;
        repeat (10) begin
            tick();
            if (dbg_cnt !== 4'd5 || rx_mute !== 1'b1 || dbg_state !== S_TURN || tx_data !== b) e++;
        end
        total++; if (e != 0) begin bad++; $display("FAIL ena_turn_freeze: got %0d bad cycles expected 0", e); end
        ena = 1'b1;
        e = 0;
        repeat (5) begin
            tick();
            if (rx_mute !== 1'b1) e++;
        end
        total++; if (e != 0) begin bad++; $display("FAIL ena_turn_resume: got %0d unmuted cycles expected 0", e); end
        tick();
        total++; if (rx_mute !== 1'b0 || dbg_state !== S_IDLE) begin bad++; $display("FAIL ena_turn_done: got mute=%b state=%b expected 0 00", rx_mute, dbg_state); end
    endtask

    task automatic test_reset_mid();
        int waited;
        req = 4'b1000;
        wait_load(4, waited);
        total++; if (gnt !== onehot(rr_pick(m_ptr, 4'b1000))) begin bad++; $display("FAIL midrst_first_gnt: got %b expected 1000", gnt); end
        req = '0;
        repeat (3) tick();
        total++; if (dbg_state !== S_SEND) begin bad++; $display("FAIL midrst_in_send: got %b expected %b", dbg_state, S_SEND); end
        rst = 1'b0;
        tick();
        total++; if (dbg_state !== S_IDLE || rx_mute !== 1'b0 || dbg_ptr !== 2'd3 || tx_load !== 1'b0) begin bad++; $display("FAIL midrst_state: got state=%b mute=%b ptr=%0d load=%b expected 00 0 3 0", dbg_state, rx_mute, dbg_ptr, tx_load); end
        rst = 1'b1;
        m_ptr = NR - 1;
        req = 4'b1001;
        wait_load(4, waited);
        total++; if (gnt !== 4'b0001 || waited != 2) begin bad++; $display("FAIL midrst_regrant: got gnt=%b after %0d expected 0001 after 2", gnt, waited); end
        m_ptr = 0;
        req = '0;
        send_frame(3);
        repeat (16) tick();
    endtask

    task automatic test_timeout();
        int waited, e;
        req = 4'b0010;
        wait_load(4, waited);
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL tmo_gnt: got %b expected 0010", gnt); end
        req = '0;
        e = 0;
`ifdef IRDA_SCHED_TIMEOUT_EN
        for (int i = 1; i <= TMO - 1; i++) begin
            tick();
            if (err !== 1'b0 || dbg_state !== S_SEND) e++;
        end
        total++; if (e != 0) begin bad++; $display("FAIL tmo_early: got %0d bad cycles expected 0", e); end
        tick();
        total++; if (err !== 1'b1 || dbg_state !== S_TURN) begin bad++; $display("FAIL tmo_pulse: got err=%b state=%b expected 1 11", err, dbg_state); end
        tick();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL tmo_pulse_width: got %b expected 0", err); end
        repeat (14) tick();
        tick();
        total++; if (dbg_state !== S_IDLE || rx_mute !== 1'b0) begin bad++; $display("FAIL tmo_idle: got state=%b mute=%b expected 00 0", dbg_state, rx_mute); end
        m_ptr = 1;
`else
        repeat (150) begin
            tick();
            if (err !== 1'b0 || dbg_state !== S_SEND || rx_mute !== 1'b1) e++;
        end
        total++; if (e != 0) begin bad++; $display("FAIL no_tmo_hold: got %0d bad cycles expected 0", e); end
        do_reset();
`endif
    endtask

    task automatic test_random();
        logic [3:0] pending, add;
        logic [7:0] b;
        int w, f, prev_f, prev_cyc, waited;
        prev_f = 0; prev_cyc = 0;
        do_reset();
        data_in = $urandom;
        pending = 4'($urandom_range(1, 15));
        req = pending;
        w = rr_pick(m_ptr, pending);
        exp_w_q.push_back(w);
        exp_q.push_back(data_in[w*8 +: 8]);
        for (int r = 0; r < 16; r++) begin
            wait_load((r == 0) ? 4 : 60, waited);
            w = exp_w_q.pop_front();
            b = exp_q.pop_front();
            total++; if (gnt !== onehot(w)) begin bad++; $display("FAIL rand_gnt_%0d: got %b expected %b", r, gnt, onehot(w)); end
            total++; if (tx_data !== b) begin bad++; $display("FAIL rand_data_%0d: got %h expected %h", r, tx_data, b); end
            if (r == 0) begin
                total++; if (waited != 2) begin bad++; $display("FAIL rand_latency: got %0d expected 2", waited); end
            end else begin
                total++; if (cyc - prev_cyc != prev_f + 18) begin bad++; $display("FAIL rand_spacing_%0d: got %0d expected %0d", r, cyc - prev_cyc, prev_f + 18); end
            end
            m_ptr = w;
            prev_cyc = cyc;
            pending[w] = 1'b0;
            data_in[w*8 +: 8] = 8'($urandom);
            if (r < 15) begin
                add = 4'($urandom_range(1, 15));
                for (int k = 0; k < NR; k++) begin
                    if (add[k] && !pending[k]) data_in[k*8 +: 8] = 8'($urandom);
                end
                pending = pending | add;
                req = pending;
                w = rr_pick(m_ptr, pending);
                exp_w_q.push_back(w);
                exp_q.push_back(data_in[w*8 +: 8]);
            end else begin
                req = '0;
            end
            f = $urandom_range(1, 15);
            prev_f = f;
            send_frame(f);
        end
        repeat (16) tick();
        total++; if (rx_mute !== 1'b0 || dbg_state !== S_IDLE) begin bad++; $display("FAIL rand_end_idle: got mute=%b state=%b expected 0 00", rx_mute, dbg_state); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_queue_drain: got %0d left expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_rx_priority();
        test_ena_freeze();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
